// File: rtl/key_debounce_module.sv
// Push-button conditioner: two-flop synchroniser, stable-time bounce filter, and
// registered level plus one-cycle press / release / long-press pulses.
module key_debounce_module #(
  parameter int T_FILTER   = 500,
  parameter int T_LONG     = 25000,
  parameter int CNT_W      = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Pin_In,
  output logic Key_Level,
  output logic Press_Pulse,
  output logic Release_Pulse,
  output logic Long_Pulse
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    PRESSED    = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  localparam logic             IDLE_LVL  = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(T_FILTER - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(T_LONG - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(T_LONG);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             act;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             key_level_q, key_level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= Pin_In;
      sync2_q <= sync1_q;
    end
  end

  assign act = sync2_q ^ IDLE_LVL;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      filt_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_cnt_q  <= filt_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    filt_cnt_d  = filt_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    key_level_d = key_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (act) begin
          state_d    = PRESS_FILT;
          filt_cnt_d = '0;
        end
      end

      PRESS_FILT: begin
        if (!act) begin
          state_d    = IDLE;
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_LAST) begin
          state_d     = PRESSED;
          press_d     = 1'b1;
          key_level_d = 1'b1;
          filt_cnt_d  = '0;
          hold_cnt_d  = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!act) begin
          state_d    = REL_FILT;
          filt_cnt_d = '0;
        end else if (hold_cnt_q < LONG_SAT) begin
          // Saturating at T_LONG guarantees a single long pulse per press.
          if (hold_cnt_q == LONG_LAST) begin
            long_d     = 1'b1;
            hold_cnt_d = LONG_SAT;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
          end
        end
      end

      REL_FILT: begin
        // hold_cnt is left untouched here so a release glitch only pauses it.
        if (act) begin
          state_d    = PRESSED;
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_LAST) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          key_level_d = 1'b0;
          filt_cnt_d  = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Key_Level     = key_level_q;
  assign Press_Pulse   = press_q;
  assign Release_Pulse = release_q;
  assign Long_Pulse    = long_q;

endmodule

// File: tb/tb_key_debounce_module.sv
// Scoreboard bench: stimulus queues expected pulse events (kind, cycle); a monitor
// on the falling edge pops and compares whenever any pulse output is high.
module tb_key_debounce_module;
  localparam int TF = 8;
  localparam int TL = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pin = 1'b1;
  logic key_level, press_p, release_p, long_p;

  key_debounce_module #(
    .T_FILTER(TF), .T_LONG(TL), .CNT_W(16), .ACTIVE_LOW(1)
  ) dut (
    .CLK(clk), .RSTn(rst_n), .Pin_In(pin),
    .Key_Level(key_level), .Press_Pulse(press_p),
    .Release_Pulse(release_p), .Long_Pulse(long_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic string kname(input int k);
    if (k == 0) return "press";
    if (k == 1) return "release";
    return "long";
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_level(input string name, input logic exp_lvl);
    checks++;
    if (key_level !== exp_lvl) begin
      errors++;
      $display("FAIL %s: Key_Level=%0b expected %0b at cycle %0d", name, key_level, exp_lvl, cyc);
    end else begin
      $display("check %s: Key_Level=%0b at cycle %0d ok", name, key_level, cyc);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({key_level, press_p, release_p, long_p} !== 4'b0000) begin
      errors++;
      $display("FAIL %s: outputs lvl/prs/rel/lng=%b expected 0000 at cycle %0d", name,
               {key_level, press_p, release_p, long_p}, cyc);
    end else begin
      $display("check %s: outputs all 0 at cycle %0d ok", name, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expected queue exactly.
  always @(negedge clk) begin
    int  n;
    int  kind;
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_%s: no pulse seen, required at cycle %0d (now %0d)",
               kname(exp_q[0].kind), exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    n = int'(press_p) + int'(release_p) + int'(long_p);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL exclusive: prs/rel/lng=%b at cycle %0d, required at most one high",
               {press_p, release_p, long_p}, cyc);
    end
    if (n > 0) begin
      kind = press_p ? 0 : (release_p ? 1 : 2);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_%s: pulse at cycle %0d, required none", kname(kind), cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
          errors++;
          $display("FAIL pulse: got %s at cycle %0d, required %s at cycle %0d",
                   kname(kind), cyc, kname(e.kind), e.cyc);
        end else begin
          $display("pulse %s at cycle %0d ok", kname(kind), cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;

    // Reset with the pin idle, then 100 quiet cycles.
    rst_n = 1'b0;
    pin   = 1'b1;
    tick(5);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(25);
      check_all_zero("post_reset_idle");
    end

    // Clean press and hold: press at k+10, long at k+50.
    pin = 1'b0;
    k = cyc + 1;
    expect_ev(0, k + TF + 2);
    expect_ev(2, k + TF + 2 + TL);
    tick(10);
    check_level("clean_before_accept", 1'b0);
    tick(1);
    check_level("clean_accepted", 1'b1);
    tick(50);
    check_level("clean_held", 1'b1);
    pin = 1'b1;
    k = cyc + 1;
    expect_ev(1, k + TF + 2);
    tick(10);
    check_level("clean_before_release", 1'b1);
    tick(1);
    check_level("clean_released", 1'b0);
    tick(10);

    // Bounce rejection: 5 low / 3 high, four times.
    for (int i = 0; i < 4; i++) begin
      pin = 1'b0;
      tick(5);
      pin = 1'b1;
      tick(3);
      check_level("bounce_reject", 1'b0);
    end
    tick(20);
    check_level("bounce_idle", 1'b0);

    // Bouncy press then bouncy release: one press, one release, no long.
    for (int i = 0; i < 6; i++) begin
      pin = 1'b0;
      tick(3);
      pin = 1'b1;
      tick(2);
    end
    pin = 1'b0;
    k = cyc + 1;
    expect_ev(0, k + TF + 2);
    tick(20);
    check_level("bouncy_pressed", 1'b1);
    for (int i = 0; i < 3; i++) begin
      pin = 1'b1;
      tick(2);
      pin = 1'b0;
      tick(2);
    end
    pin = 1'b1;
    k = cyc + 1;
    expect_ev(1, k + TF + 2);
    tick(9);
    check_level("bouncy_rel_filter", 1'b1);
    tick(2);
    check_level("bouncy_released", 1'b0);
    tick(60);
    check_level("bouncy_idle", 1'b0);

    // Release glitch during hold: 4 non-counting edges push long to P+44.
    pin = 1'b0;
    k = cyc + 1;
    expect_ev(0, k + 10);
    expect_ev(2, k + 54);
    tick(30);
    pin = 1'b1;
    tick(3);
    pin = 1'b0;
    check_level("glitch_in_rel_filt", 1'b1);
    tick(20);
    check_level("glitch_still_pressed", 1'b1);
    tick(10);
    pin = 1'b1;
    k = cyc + 1;
    expect_ev(1, k + 10);
    tick(20);
    check_level("glitch_released", 1'b0);

    // Reset while pressed: no release, re-detected 10 cycles after reset release.
    pin = 1'b0;
    k = cyc + 1;
    expect_ev(0, k + 10);
    tick(20);
    check_level("rst_mid_pressed", 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_immediate");
    tick(3);
    check_all_zero("rst_mid_held");
    rst_n = 1'b1;
    k = cyc + 1;
    expect_ev(0, k + 10);
    expect_ev(2, k + 50);
    tick(10);
    check_level("rst_redetect_before", 1'b0);
    tick(1);
    check_level("rst_redetect_after", 1'b1);
    tick(50);
    pin = 1'b1;
    k = cyc + 1;
    expect_ev(1, k + 10);
    tick(20);
    check_level("final_released", 1'b0);
    tick(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
